// File: rtl/instr_inv_queue_if.sv
// Invalidation-queue bus: store-commit side (in_*) and icache/BP side (out_*),
// plus the empty/count status used for fence.i draining.
//   slave  : the queue itself (accepts in_*, produces out_*, empty, count)
//   master : the surrounding core/testbench
interface instr_inv_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [31:0]   in_addr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_addr;
    logic          out_ack;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_addr, out_ack,
        output in_ready, out_valid, out_addr, empty, count
    );

    modport master (
        output in_valid, in_addr, out_ack,
        input  in_ready, out_valid, out_addr, empty, count
    );
endinterface

// File: rtl/instr_inv_queue.sv
// Queue of committed-store line addresses awaiting icache/branch-predictor
// invalidation. Stores outside the icache range are dropped, and a store that
// hits the same line as the newest queued entry is merged into it.
// Ports:
//   clk  - core clock
//   rst  - synchronous, active-high reset; discards all entries
//   bus  - instr_inv_queue_if.slave
//          in_valid/in_addr/in_ready : store address handshake
//          out_valid/out_addr/out_ack: head line address to invalidate
//          empty                     : nothing pending (fence.i may complete)
//          count                     : occupancy 0..DEPTH
module instr_inv_queue #(
    parameter int          DEPTH  = 4,
    parameter logic [31:0] ADDR_L = 32'h8000_0000,
    parameter logic [31:0] ADDR_H = 32'h8FFF_FFFF,
    parameter int          LINE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    instr_inv_queue_if.slave bus
);
    localparam int          PW    = $clog2(DEPTH);
    localparam int          CW    = PW + 1;
    localparam int          OFF   = 2 + $clog2(LINE_W);
    localparam logic [31:0] LMASK = (32'd1 << OFF) - 32'd1;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [31:0]   last_line;

    logic [31:0] in_line;
    logic        in_range;
    logic        is_empty;
    logic        is_full;
    logic        pop;
    logic        coalesce;
    logic        push;

    assign in_line  = bus.in_addr & ~LMASK;
    assign in_range = (bus.in_addr >= ADDR_L) && (bus.in_addr <= ADDR_H);
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign pop      = !is_empty && bus.out_ack;

    // While the queue is non-empty the newest entry is by construction the
    // last one written, so last_line is only meaningful under !is_empty.
    // If that single entry is being popped this cycle, the new store must be
    // re-enqueued rather than merged into a line that is already leaving.
    assign coalesce = !is_empty && (in_line == last_line)
                      && !((cnt == CW'(1)) && bus.out_ack);
    assign push     = bus.in_valid && !is_full && in_range && !coalesce;

    assign bus.in_ready  = !is_full;
    assign bus.out_valid = !is_empty;
    assign bus.empty     = is_empty;
    assign bus.count     = cnt;
    assign bus.out_addr  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            last_line <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_line;
                wr_ptr      <= wr_ptr + PW'(1);
                last_line   <= in_line;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
